// File: rtl/reg_wport_arbiter_pkg.sv
// reg_wport_arbiter_pkg: shared widths, zero register and write-port grant source encoding
package reg_wport_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ZERO_REG = 0;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_FIFO, GNT_BYP} gnt_e;
endpackage

// File: rtl/reg_wport_arbiter_wport_fifo.sv
// reg_wport_arbiter_wport_fifo: power-of-two sync FIFO with full/empty and same-cycle push/pop
module reg_wport_arbiter_wport_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rp_q, wp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Storage carries no reset; only the pointers and count decide what is valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= data_i;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/reg_wport_arbiter.sv
// reg_wport_arbiter: shares the register-file write port between WB and a multi-cycle unit
module reg_wport_arbiter
  import reg_wport_arbiter_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MC_DEPTH       = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_rd,
  input  logic [REG_DATA_WIDTH-1:0]   wb_data,
  input  logic                        mc_valid,
  output logic                        mc_ready,
  input  logic [REG_ADDR_WIDTH-1:0]   mc_rd,
  input  logic [REG_DATA_WIDTH-1:0]   mc_data,
  input  logic                        mc_issue,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rd,
  output logic                        RegWrite_out,
  output logic [REG_ADDR_WIDTH-1:0]   rd_out,
  output logic [REG_DATA_WIDTH-1:0]   write_data_out,
  output logic                        stall_out,
  output logic [2**REG_ADDR_WIDTH-1:0] busy_vec
);
  localparam int NREG = 2**REG_ADDR_WIDTH;
  localparam int EW   = REG_ADDR_WIDTH + REG_DATA_WIDTH;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = $clog2(MC_DEPTH) + 1;
  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(ZERO_REG);

  logic [EW-1:0] head;
  logic [REG_ADDR_WIDTH-1:0] head_rd, grant_rd;
  logic [REG_DATA_WIDTH-1:0] head_data, grant_data;
  logic [CW-1:0] count;
  logic full, empty, push, pop, wb_win, nxt_empty, issue, mc_grant;
  gnt_e gnt;
  logic [SW-1:0] starve_q, starve_d;
  logic drain_q, drain_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign {head_rd, head_data} = head;

  reg_wport_arbiter_wport_fifo #(.DEPTH(MC_DEPTH), .WIDTH(EW)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i({mc_rd, mc_data}),
    .head_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );

  // Grant priority: WB, then FIFO head, then same-cycle bypass of a fresh result; outputs forced to 0 in reset
  always_comb begin
    wb_win         = wb_regwrite && wb_rd != X0;
    gnt            = wb_win ? GNT_WB : !empty ? GNT_FIFO : mc_valid ? GNT_BYP : GNT_NONE;
    mc_grant       = gnt == GNT_FIFO || gnt == GNT_BYP;
    grant_rd       = gnt == GNT_WB ? wb_rd : gnt == GNT_FIFO ? head_rd : gnt == GNT_BYP ? mc_rd : X0;
    grant_data     = gnt == GNT_WB ? wb_data : gnt == GNT_FIFO ? head_data : gnt == GNT_BYP ? mc_data : '0;
    pop            = gnt == GNT_FIFO;
    push           = mc_valid && !full && gnt != GNT_BYP;
    RegWrite_out   = rst && gnt != GNT_NONE && grant_rd != X0;
    rd_out         = rst ? grant_rd : X0;
    write_data_out = rst ? grant_data : '0;
    mc_ready       = rst && !full;
    stall_out      = rst && (drain_q || busy_q[id_rs1] || busy_q[id_rs2] || busy_q[id_rd]);
    issue          = mc_issue && !stall_out && id_rd != X0;
  end

  // Starvation tracking, drain hold-off until the FIFO empties, and pending-write scoreboard
  always_comb begin
    starve_d  = pop ? '0 : (!empty && wb_win && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    nxt_empty = (empty || (pop && count == CW'(1))) && !push;
    drain_d   = !nxt_empty && (drain_q || starve_d == SW'(STARVE_LIMIT));
    busy_d    = busy_q;
    if (mc_grant) busy_d[grant_rd] = 1'b0;
    if (issue) busy_d[id_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // State registers, cleared asynchronously so reset discards all pending multi-cycle work
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      starve_q <= '0;
      drain_q  <= 1'b0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
    end

  assign busy_vec = busy_q;
endmodule

// File: tb/tb_reg_wport_arbiter.sv
// tb_reg_wport_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_reg_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_regwrite, mc_valid, mc_issue, mc_ready, RegWrite_out, stall_out;
  logic [4:0] wb_rd, mc_rd, id_rs1, id_rs2, id_rd, rd_out;
  logic [31:0] wb_data, mc_data, write_data_out, busy_vec;

  always #5 clk = ~clk;

  reg_wport_arbiter #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32), .MC_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_issue(mc_issue), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .RegWrite_out(RegWrite_out), .rd_out(rd_out), .write_data_out(write_data_out),
    .stall_out(stall_out), .busy_vec(busy_vec)
  );

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic wr; logic [4:0] wrd; logic [31:0] wd;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic iss; logic [4:0] r1, r2, ird;
    logic we; logic [4:0] erd; logic [31:0] ed;
    logic rdy, stl; logic [31:0] busy;
  } vec_t;

  typedef struct packed {logic [4:0] rd; logic [31:0] d;} ent_t;
  typedef struct {logic [4:0] rd; int due;} op_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int wr, input int wrd, input int wd, input int mv, input int mrd,
                       input int md, input int iss, input int r1, input int r2, input int ird);
    wb_regwrite = 1'(wr); wb_rd = 5'(wrd); wb_data = 32'(wd);
    mc_valid = 1'(mv); mc_rd = 5'(mrd); mc_data = 32'(md);
    mc_issue = 1'(iss); id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(ird);
  endtask

  task automatic exp_out(input string nm, input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic rdy, input logic stl, input logic [31:0] busy);
    @(negedge clk);
    chk({nm, ".we"}, 32'(RegWrite_out), 32'(we));
    if (we) begin
      chk({nm, ".rd"}, 32'(rd_out), 32'(rd));
      chk({nm, ".data"}, write_data_out, d);
    end
    chk({nm, ".ready"}, 32'(mc_ready), 32'(rdy));
    chk({nm, ".stall"}, 32'(stall_out), 32'(stl));
    chk({nm, ".busy"}, busy_vec, busy);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [13];
  ent_t q [$];
  op_t pend [$];
  logic [31:0] mbusy;
  int mstarve;
  logic mdrain, pres;
  logic [4:0] prd;
  logic [31:0] pdat;

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 32'h200};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99,      1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99,      1'b1, 1'b1, 32'h200};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6, 32'h66,      1'b1, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd13, 32'hD13,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33,      1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd13, 32'hD13,    1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 32'h0};

    drive(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0);
    @(negedge clk);
    chk("in_reset.we", 32'(RegWrite_out), 32'h0);
    chk("in_reset.rd", 32'(rd_out), 32'h0);
    chk("in_reset.data", write_data_out, 32'h0);
    chk("in_reset.ready", 32'(mc_ready), 32'h0);
    chk("in_reset.stall", 32'(stall_out), 32'h0);
    chk("in_reset.busy", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].wr, tbl[i].wrd, tbl[i].wd, tbl[i].mv, tbl[i].mrd, tbl[i].md,
            tbl[i].iss, tbl[i].r1, tbl[i].r2, tbl[i].ird);
      exp_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].erd, tbl[i].ed, tbl[i].rdy, tbl[i].stl, tbl[i].busy);
    end

    drive(1, 3, 3, 1, 7, 32'h77, 0, 0, 0, 0);  exp_out("drain_a0", 1, 3, 3, 1, 0, 0);
    drive(1, 3, 3, 1, 8, 32'h88, 0, 0, 0, 0);  exp_out("drain_a1", 1, 3, 3, 1, 0, 0);
    drive(1, 3, 3, 1, 14, 32'hE, 0, 0, 0, 0);  exp_out("drain_a2", 1, 3, 3, 0, 0, 0);
    exp_out("drain_a3", 1, 3, 3, 0, 0, 0);
    exp_out("drain_a4", 1, 3, 3, 0, 0, 0);
    exp_out("drain_a5", 1, 3, 3, 0, 1, 0);
    drive(0, 0, 0, 1, 14, 32'hE, 0, 0, 0, 0);  exp_out("drain_a6", 1, 7, 32'h77, 0, 1, 0);
    exp_out("drain_a7", 1, 8, 32'h88, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       exp_out("drain_a8", 1, 14, 32'hE, 1, 1, 0);
    exp_out("drain_a9", 0, 0, 0, 1, 0, 0);

    drive(1, 3, 3, 1, 10, 32'h10, 0, 0, 0, 0); exp_out("order_b0", 1, 3, 3, 1, 0, 0);
    drive(1, 3, 3, 1, 11, 32'h11, 0, 0, 0, 0); exp_out("order_b1", 1, 3, 3, 1, 0, 0);
    drive(0, 0, 0, 1, 12, 32'h12, 0, 0, 0, 0); exp_out("order_b2", 1, 10, 32'h10, 0, 0, 0);
    exp_out("order_b3", 1, 11, 32'h11, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       exp_out("order_b4", 1, 12, 32'h12, 1, 0, 0);
    exp_out("order_b5", 0, 0, 0, 1, 0, 0);

    drive(1, 3, 3, 1, 21, 32'h2121, 1, 0, 0, 20); exp_out("arst_c0", 1, 3, 3, 1, 0, 0);
    drive(1, 3, 3, 1, 22, 32'h2222, 1, 0, 0, 23); exp_out("arst_c1", 1, 3, 3, 1, 0, 32'h0010_0000);
    drive(1, 3, 3, 0, 0, 0, 0, 20, 0, 0);
    #2;
    chk("arst_pre.stall", 32'(stall_out), 32'h1);
    chk("arst_pre.ready", 32'(mc_ready), 32'h0);
    chk("arst_pre.busy", busy_vec, 32'h0090_0000);
    rst = 1'b0;
    #1;
    chk("arst_now.we", 32'(RegWrite_out), 32'h0);
    chk("arst_now.rd", 32'(rd_out), 32'h0);
    chk("arst_now.data", write_data_out, 32'h0);
    chk("arst_now.ready", 32'(mc_ready), 32'h0);
    chk("arst_now.stall", 32'(stall_out), 32'h0);
    chk("arst_now.busy", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 20, 23, 0);
    exp_out("arst_rel0", 0, 0, 0, 1, 0, 0);
    exp_out("arst_rel1", 0, 0, 0, 1, 0, 0);

    mbusy = '0; mstarve = 0; mdrain = 1'b0; pres = 1'b0; prd = '0; pdat = '0;
    for (int c = 0; c < 1500; c++) begin
      logic wr, iss, wbw, byp, pop, push, ewe, erdy, estl;
      logic [4:0] wrd, r1, r2, ird, erd;
      logic [31:0] wd, ed;
      int sz0;
      if (!pres && pend.size() > 0 && pend[0].due <= c && $urandom_range(0, 1) == 1) begin
        pres = 1'b1;
        prd = pend[0].rd;
        pdat = $urandom;
        pend.delete(0);
      end
      wr = 1'($urandom_range(0, 1)); wrd = 5'($urandom_range(0, 31)); wd = $urandom;
      iss = $urandom_range(0, 2) == 0; ird = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
      sz0 = q.size();
      wbw = wr && wrd != 0;
      if (wbw) begin ewe = 1'b1; erd = wrd; ed = wd; end
      else if (sz0 > 0) begin ewe = q[0].rd != 0; erd = q[0].rd; ed = q[0].d; end
      else if (pres) begin ewe = prd != 0; erd = prd; ed = pdat; end
      else begin ewe = 1'b0; erd = '0; ed = '0; end
      erdy = sz0 < DEPTH;
      estl = mdrain || mbusy[r1] || mbusy[r2] || mbusy[ird];
      drive(wr, wrd, wd, pres, prd, pdat, iss, r1, r2, ird);
      exp_out("rnd", ewe, erd, ed, erdy, estl, mbusy);
      pop = !wbw && sz0 > 0;
      byp = !wbw && sz0 == 0 && pres;
      push = pres && erdy && !byp;
      if (pop) begin mbusy[q[0].rd] = 1'b0; q.delete(0); end
      if (byp) mbusy[prd] = 1'b0;
      if (iss && !estl && ird != 0) mbusy[ird] = 1'b1;
      if (iss && !estl) pend.push_back('{ird, c + 3});
      if (push) q.push_back('{prd, pdat});
      if (push || byp) pres = 1'b0;
      mbusy[0] = 1'b0;
      mstarve = pop ? 0 : (sz0 > 0 && wbw && mstarve < LIMIT) ? mstarve + 1 : mstarve;
      mdrain = (mdrain || mstarve == LIMIT) && q.size() != 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
